truth_table_checker: RTL and testbench

//   Response-side counterpart to the gate stimulus drivers: samples each applied input vector

---
 rtl/tc_check_pkg.sv | 16 +
 rtl/tt_cov_tracker.sv | 27 ++
 rtl/truth_table_checker.sv | 143 ++++++++++++++
 tb/tb_truth_table_checker.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tc_check_pkg.sv
// Shared types and helpers for the truth-table response checker.
package tc_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } tc_state_t;

    // Tables up to 2**6 entries are passed zero-extended to 64 bits.
    function automatic logic tt_lookup(input logic [63:0] tbl, input logic [5:0] vec);
        return tbl[vec];
    endfunction

endpackage

// File: rtl/tt_cov_tracker.sv
// Sticky per-run coverage bitmap: one bit per input vector, cleared at run start.
module tt_cov_tracker #(
    parameter int unsigned N_IN = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 set_i,
    input  logic [N_IN-1:0]      set_idx_i,
    output logic [2**N_IN-1:0]   cov_map_o,
    output logic                 full_o
);

    logic [2**N_IN-1:0] cov_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            cov_q <= '0;
        end else if (set_i) begin
            cov_q[set_idx_i] <= 1'b1;
        end
    end

    assign cov_map_o = cov_q;
    assign full_o    = &cov_q;

endmodule

// File: rtl/truth_table_checker.sv
// Scores sampled DUT responses against a truth table: two-stage pipeline,
// saturating counters, coverage bitmap and first-failure capture.
module truth_table_checker
    import tc_check_pkg::*;
#(
    parameter int unsigned        N_IN        = 3,
    parameter logic [2**N_IN-1:0] TRUTH_TABLE = 'hFE,
    parameter int unsigned        MAX_SAMPLES = 64,
    parameter int unsigned        CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN-1:0]      in_vec,
    input  logic                 dut_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     sample_count,
    output logic [2**N_IN-1:0]   cov_map,
    output logic                 first_fail_valid,
    output logic [N_IN-1:0]      first_fail_vec,
    output logic                 first_fail_got
);

    localparam int unsigned NV = 2**N_IN;
    localparam int unsigned BW = $clog2(MAX_SAMPLES + 1);

    tc_state_t         state_q, state_d;
    logic              stg_vld_q;
    logic [N_IN-1:0]   stg_vec_q;
    logic              stg_y_q;
    logic [BW-1:0]     acc_q;
    logic [CNT_W-1:0]  err_q, smp_q;
    logic              ffv_q, ffgot_q;
    logic [N_IN-1:0]   ffvec_q;
    logic              cov_full;

    logic              accept, expected, mismatch, budget_hit, full_hit;
    logic [NV-1:0]     cov_la;

    assign accept   = (state_q == RUN) && in_valid && !start;
    assign expected = tt_lookup(64'(TRUTH_TABLE), 6'(stg_vec_q));
    assign mismatch = stg_vld_q && (stg_y_q !== expected);

    // Coverage lookahead must include the sample still in stage 0 as well as
    // the one being accepted, since cov_map lags acceptance by a cycle.
    assign cov_la     = cov_map
                      | (stg_vld_q ? (NV'(1) << stg_vec_q) : '0)
                      | (NV'(1) << in_vec);
    assign full_hit   = accept && (&cov_la);
    assign budget_hit = accept && (acc_q == BW'(MAX_SAMPLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (start)                       state_d = RUN;
                else if (budget_hit || full_hit) state_d = FLUSH;
            end
            FLUSH: begin
                busy    = 1'b1;
                state_d = start ? RUN : DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            stg_vld_q <= 1'b0;
            stg_vec_q <= '0;
            stg_y_q   <= 1'b0;
            acc_q     <= '0;
            smp_q     <= '0;
        end else begin
            stg_vld_q <= accept;
            if (accept) begin
                stg_vec_q <= in_vec;
                stg_y_q   <= dut_y;
                acc_q     <= acc_q + 1'b1;
                if (smp_q != '1) smp_q <= smp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            ffgot_q <= 1'b0;
        end else if (mismatch) begin
            if (err_q != '1) err_q <= err_q + 1'b1;
            if (!ffv_q) begin
                ffv_q   <= 1'b1;
                ffvec_q <= stg_vec_q;
                ffgot_q <= stg_y_q;
            end
        end
    end

    tt_cov_tracker #(.N_IN(N_IN)) u_cov (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (start),
        .set_i     (stg_vld_q),
        .set_idx_i (stg_vec_q),
        .cov_map_o (cov_map),
        .full_o    (cov_full)
    );

    assign pass             = done && (err_q == '0) && cov_full;
    assign err_count        = err_q;
    assign sample_count     = smp_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_got   = ffgot_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker configured as an or3 scorer.
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_vec;
    logic       dut_y;
    logic       start_m, start_b, start_s;

    logic       rdy_m, busy_m, done_m, pass_m, ffv_m, ffg_m;
    logic [7:0] err_m, smp_m, cov_m;
    logic [2:0] ffvec_m;

    logic       rdy_b, busy_b, done_b, pass_b, ffv_b, ffg_b;
    logic [7:0] err_b, smp_b, cov_b;
    logic [2:0] ffvec_b;

    logic       rdy_s, busy_s, done_s, pass_s, ffv_s, ffg_s;
    logic [1:0] err_s, smp_s;
    logic [7:0] cov_s;
    logic [2:0] ffvec_s;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    truth_table_checker #(.N_IN(3), .TRUTH_TABLE(8'hFE), .MAX_SAMPLES(64), .CNT_W(8)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start_m), .in_valid(in_valid), .in_ready(rdy_m),
        .in_vec(in_vec), .dut_y(dut_y), .busy(busy_m), .done(done_m), .pass(pass_m),
        .err_count(err_m), .sample_count(smp_m), .cov_map(cov_m),
        .first_fail_valid(ffv_m), .first_fail_vec(ffvec_m), .first_fail_got(ffg_m));

    truth_table_checker #(.N_IN(3), .TRUTH_TABLE(8'hFE), .MAX_SAMPLES(4), .CNT_W(8)) u_bud (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
        .in_vec(in_vec), .dut_y(dut_y), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .sample_count(smp_b), .cov_map(cov_b),
        .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b), .first_fail_got(ffg_b));

    truth_table_checker #(.N_IN(3), .TRUTH_TABLE(8'hFE), .MAX_SAMPLES(64), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(in_valid), .in_ready(rdy_s),
        .in_vec(in_vec), .dut_y(dut_y), .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_count(err_s), .sample_count(smp_s), .cov_map(cov_s),
        .first_fail_valid(ffv_s), .first_fail_vec(ffvec_s), .first_fail_got(ffg_s));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one sample across exactly one active edge.
    task automatic send(input logic [2:0] v, input logic y);
        in_valid = 1'b1;
        in_vec   = v;
        dut_y    = y;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start_m();
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
    endtask

    task automatic run_or3_clean(input string tag);
        for (int unsigned k = 0; k < 8; k++) send(3'(k), (k != 0));
        check_eq({tag, "_flush_done"}, 32'(done_m), 0);
        check_eq({tag, "_flush_busy"}, 32'(busy_m), 1);
        tick();
        check_eq({tag, "_done"}, 32'(done_m), 1);
        check_eq({tag, "_pass"}, 32'(pass_m), 1);
        check_eq({tag, "_err"},  32'(err_m), 0);
        check_eq({tag, "_cov"},  32'(cov_m), 32'hFF);
        check_eq({tag, "_smp"},  32'(smp_m), 8);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; dut_y = 1'b0;
        start_m = 1'b0; start_b = 1'b0; start_s = 1'b0;
        tick(); tick();
        check_eq("rst_ready", 32'(rdy_m), 0);
        check_eq("rst_busy",  32'(busy_m), 0);
        check_eq("rst_done",  32'(done_m), 0);
        check_eq("rst_err",   32'(err_m), 0);
        check_eq("rst_cov",   32'(cov_m), 0);
        check_eq("rst_ffv",   32'(ffv_m), 0);
        rst_n = 1'b1;
        tick();

        // 1: clean or3 sweep, with pipeline timing of first samples
        pulse_start_m();
        check_eq("t1_ready", 32'(rdy_m), 1);
        send(3'd0, 1'b0);
        check_eq("t1_smp_first", 32'(smp_m), 1);
        check_eq("t1_cov_lag",   32'(cov_m), 0);
        send(3'd1, 1'b1);
        check_eq("t1_cov_first", 32'(cov_m), 32'h01);
        for (int unsigned k = 2; k < 8; k++) send(3'(k), 1'b1);
        check_eq("t1_flush_done", 32'(done_m), 0);
        check_eq("t1_flush_rdy",  32'(rdy_m), 0);
        tick();
        check_eq("t1_done", 32'(done_m), 1);
        check_eq("t1_busy", 32'(busy_m), 0);
        check_eq("t1_pass", 32'(pass_m), 1);
        check_eq("t1_err",  32'(err_m), 0);
        check_eq("t1_cov",  32'(cov_m), 32'hFF);
        check_eq("t1_smp",  32'(smp_m), 8);

        // 2: vector 0 wrong, remainder correct; start from DONE clears results
        pulse_start_m();
        check_eq("t2_clr_cov",  32'(cov_m), 0);
        check_eq("t2_clr_smp",  32'(smp_m), 0);
        check_eq("t2_clr_done", 32'(done_m), 0);
        send(3'd0, 1'b1);
        for (int unsigned k = 1; k < 8; k++) send(3'(k), 1'b1);
        tick();
        check_eq("t2_done",  32'(done_m), 1);
        check_eq("t2_err",   32'(err_m), 1);
        check_eq("t2_ffv",   32'(ffv_m), 1);
        check_eq("t2_ffvec", 32'(ffvec_m), 0);
        check_eq("t2_ffgot", 32'(ffg_m), 1);
        check_eq("t2_pass",  32'(pass_m), 0);

        // 4: restart mid-run with a colliding sample, then a fresh clean run
        pulse_start_m();
        send(3'd0, 1'b0); send(3'd1, 1'b0); send(3'd2, 1'b1);
        check_eq("t4_pre_err", 32'(err_m), 1);
        start_m = 1'b1; in_valid = 1'b1; in_vec = 3'd3; dut_y = 1'b1;
        tick();
        start_m = 1'b0; in_valid = 1'b0;
        check_eq("t4_err", 32'(err_m), 0);
        check_eq("t4_smp", 32'(smp_m), 0);
        check_eq("t4_cov", 32'(cov_m), 0);
        check_eq("t4_ffv", 32'(ffv_m), 0);
        check_eq("t4_rdy", 32'(rdy_m), 1);
        tick();
        check_eq("t4_stage_dropped", 32'(cov_m), 0);
        run_or3_clean("t4run");

        // 5: reset mid-run
        pulse_start_m();
        send(3'd1, 1'b0); send(3'd2, 1'b1);
        rst_n = 1'b0; in_valid = 1'b1; in_vec = 3'd3; dut_y = 1'b1;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        check_eq("t5_rdy",  32'(rdy_m), 0);
        check_eq("t5_busy", 32'(busy_m), 0);
        check_eq("t5_err",  32'(err_m), 0);
        check_eq("t5_smp",  32'(smp_m), 0);
        check_eq("t5_ffv",  32'(ffv_m), 0);
        send(3'd4, 1'b1);
        check_eq("t5_idle_smp", 32'(smp_m), 0);
        tick();
        check_eq("t5_idle_cov", 32'(cov_m), 0);
        pulse_start_m();
        check_eq("t5_rdy_after_start", 32'(rdy_m), 1);

        // 3: sample budget of 4 on a single vector
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int unsigned k = 0; k < 3; k++) send(3'd5, 1'b1);
        check_eq("t3_busy_mid", 32'(busy_b), 1);
        send(3'd5, 1'b1);
        check_eq("t3_rdy_flush", 32'(rdy_b), 0);
        tick();
        check_eq("t3_done", 32'(done_b), 1);
        check_eq("t3_cov",  32'(cov_b), 32'h20);
        check_eq("t3_pass", 32'(pass_b), 0);
        check_eq("t3_smp",  32'(smp_b), 4);
        check_eq("t3_err",  32'(err_b), 0);

        // 6: 2-bit counters saturate; first failure not overwritten
        start_s = 1'b1; tick(); start_s = 1'b0;
        send(3'd0, 1'b1); send(3'd2, 1'b0); send(3'd4, 1'b0);
        send(3'd6, 1'b0); send(3'd1, 1'b0);
        tick();
        check_eq("t6_err",   32'(err_s), 3);
        check_eq("t6_smp",   32'(smp_s), 3);
        check_eq("t6_ffvec", 32'(ffvec_s), 0);
        check_eq("t6_ffgot", 32'(ffg_s), 1);
        check_eq("t6_cov",   32'(cov_s), 32'h57);
        check_eq("t6_busy",  32'(busy_s), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
